svk_ahb_slv_mem: RTL and testbench

SVK_AHB_SLV_MEM -- requirements
Module: svk_ahb_slv_mem

---
 rtl/svk_ahb_pkg.sv | 42 ++++
 rtl/svk_ahb_slv_ram.sv | 28 ++
 rtl/svk_ahb_slv_mem.sv | 127 ++++++++++++
 tb/tb_svk_ahb_slv_mem.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/svk_ahb_pkg.sv
// Shared AHB types for the svk AHB slave memory: transfer/response/size encodings,
// slave FSM states and the byte-lane decode used on writes.
package svk_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1,
        HRESP_RETRY = 2'd2,
        HRESP_SPLIT = 2'd3
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

    function automatic logic [3:0] ahb_byte_lanes(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] lanes;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << a;
            HSIZE_HALF: lanes = 4'b0011 << a;
            default:    lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/svk_ahb_slv_ram.sv
// Word-organised storage for the AHB slave: one byte-enabled write port and one
// asynchronous read port. Contents are deliberately not reset.
module svk_ahb_slv_ram #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/svk_ahb_slv_mem.sv
// AHB-Lite slave memory with ERROR response on bad accesses and optional OKAY wait
// states (built only when SVK_AHB_SLV_WAIT_EN is defined).
//   state   | meaning
//   IDLE    | hready=1; completes a pending OKAY data phase, accepts new address phases
//   WAIT    | hready=0, OKAY; wait-state down-counter running
//   ERR1    | hready=0, ERROR; first cycle of the two-cycle error response
//   ERR2    | hready=1, ERROR; may accept the next address phase
module svk_ahb_slv_mem
    import svk_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready_in,
    output logic                  hready,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int BA = $clog2(MEM_BYTES);
`ifdef SVK_AHB_SLV_WAIT_EN
    localparam bit WAIT_ON = (WAIT_CYCLES > 0);
`else
    localparam bit WAIT_ON = 1'b0;
`endif

    slv_state_e    r_state, w_state_nxt;
    logic          r_dp_valid;
    logic          r_write;
    logic [BA-1:0] r_addr;
    logic [2:0]    r_size;

    logic          w_accept, w_err, w_misalign, w_cnt_tc, w_we;
    logic [31:0]   w_rdata;
    logic          w_unused;

    // Burst type and protection carry no meaning here; every beat decodes alone.
    assign w_unused = ^{hburst, hprot};

    assign w_accept   = hsel & hready_in & (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign w_misalign = ((hsize == HSIZE_HALF) & haddr[0]) |
                        ((hsize == HSIZE_WORD) & (|haddr[1:0]));
    assign w_err      = (haddr >= ADDR_WIDTH'(MEM_BYTES)) | (hsize > HSIZE_WORD) | w_misalign;

`ifdef SVK_AHB_SLV_WAIT_EN
    logic [3:0] r_cnt;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_cnt <= 4'd0;
        end else if (hready && w_accept && !w_err) begin
            r_cnt <= WAIT_ON ? 4'(WAIT_CYCLES - 1) : 4'd0;
        end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign w_cnt_tc = (r_cnt == 4'd0);
`else
    assign w_cnt_tc = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                if (!w_accept)  w_state_nxt = ST_IDLE;
                else if (w_err) w_state_nxt = ST_ERR1;
                else            w_state_nxt = WAIT_ON ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: if (w_cnt_tc) w_state_nxt = ST_IDLE;
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state    <= ST_IDLE;
            r_dp_valid <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_size     <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (hready) begin
                // Only OKAY transfers open a data phase; errors live in ERR1/ERR2 alone.
                r_dp_valid <= w_accept & ~w_err;
                if (w_accept) begin
                    r_addr  <= haddr[BA-1:0];
                    r_write <= hwrite;
                    r_size  <= hsize;
                end
            end
        end
    end

    assign hready = (r_state != ST_WAIT) && (r_state != ST_ERR1);
    assign hresp  = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign w_we   = (r_state == ST_IDLE) & r_dp_valid & r_write;
    assign hrdata = (r_dp_valid & ~r_write) ? w_rdata : '0;

    svk_ahb_slv_ram #(
        .WORDS (MEM_BYTES / 4)
    ) u_ram (
        .i_clk   (hclk),
        .i_we    (w_we),
        .i_be    (ahb_byte_lanes(r_size, r_addr[1:0])),
        .i_waddr (r_addr[BA-1:2]),
        .i_wdata (hwdata),
        .i_raddr (r_addr[BA-1:2]),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_svk_ahb_slv_mem.sv
// Directed bench for svk_ahb_slv_mem; expected wait states follow SVK_AHB_SLV_WAIT_EN.
module tb_svk_ahb_slv_mem;

    localparam int WC = 2;
`ifdef SVK_AHB_SLV_WAIT_EN
    localparam int EXP_W = WC;
`else
    localparam int EXP_W = 0;
`endif

    logic        hclk, hreset, hsel, hwrite, hready_in, hready;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans, hresp;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int n_chk = 0;
    int n_fail = 0;

    logic        op_wr   [8];
    logic [31:0] op_addr [8];
    logic [31:0] op_data [8];

    assign hready_in = hready;

    svk_ahb_slv_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_BYTES  (1024),
        .WAIT_CYCLES(WC)
    ) dut (
        .hclk     (hclk),
        .hreset   (hreset),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hprot    (hprot),
        .hwdata   (hwdata),
        .hready_in(hready_in),
        .hready   (hready),
        .hresp    (hresp),
        .hrdata   (hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single non-pipelined transfer; entered and left at posedge+1 with the bus idle.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata);
        int lo;
        logic [1:0] resp_lo;
        int exp_lo;
        exp_lo  = exp_err ? 1 : EXP_W;
        lo      = 0;
        resp_lo = 2'd0;
        hsel = 1'b1; htrans = 2'd2; haddr = addr; hwrite = wr; hsize = size;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = wdata;
        for (int i = 0; i < 20; i++) begin
            @(negedge hclk);
            if (hready) break;
            if (lo == 0) resp_lo = hresp;
            lo++;
        end
        chk({tag, "_wait"}, 32'(lo), 32'(exp_lo));
        if (lo > 0) chk({tag, "_resp_lo"}, 32'(resp_lo), {31'd0, exp_err});
        chk({tag, "_resp"}, 32'(hresp), {31'd0, exp_err});
        chk({tag, "_rdata"}, hrdata, (wr || exp_err) ? 32'd0 : exp_rdata);
        @(posedge hclk); #1;
    endtask

    // Back-to-back word transfers from op_* arrays; address of beat k overlaps data of k-1.
    task automatic pipe(input int n);
        int lo_total;
        int resp_bad;
        lo_total = 0;
        resp_bad = 0;
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                hsel = 1'b1; htrans = (k == 0) ? 2'd2 : 2'd3; haddr = op_addr[k];
                hwrite = op_wr[k]; hsize = 3'd2; hburst = 3'b001;
            end else begin
                hsel = 1'b0; htrans = 2'd0; hburst = 3'b000;
            end
            if (k > 0) hwdata = op_wr[k-1] ? op_data[k-1] : 32'd0;
            for (int i = 0; i < 20; i++) begin
                @(negedge hclk);
                if (hready) break;
                lo_total++;
            end
            if (hresp != 2'd0) resp_bad++;
            if (k > 0 && !op_wr[k-1]) chk($sformatf("pipe_rd%0d", k - 1), hrdata, op_data[k-1]);
            @(posedge hclk); #1;
        end
        chk("pipe_wait_total", 32'(lo_total), 32'(n * EXP_W));
        chk("pipe_resp", 32'(resp_bad), 32'd0);
    endtask

    initial begin
        hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'd0; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hwdata = '0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hready", {31'd0, hready}, 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        hreset = 1'b0;
        @(posedge hclk); #1;

        xfer("w10",   1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
        xfer("r10a",  1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);
        @(negedge hclk);
        chk("idle_hrdata", hrdata, 32'd0);
        @(posedge hclk); #1;
        xfer("wb11",  1'b1, 32'h11, 3'd0, 32'h0000AA00, 1'b0, 32'h0);
        xfer("r10b",  1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hDEADAAEF);
        xfer("r400",  1'b0, 32'h400, 3'd2, 32'h0, 1'b1, 32'h0);
        xfer("w410",  1'b1, 32'h410, 3'd2, 32'h11111111, 1'b1, 32'h0);
        xfer("wh13",  1'b1, 32'h13, 3'd1, 32'h55555555, 1'b1, 32'h0);
        xfer("ws3",   1'b1, 32'h10, 3'd3, 32'h22222222, 1'b1, 32'h0);
        xfer("r10c",  1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hDEADAAEF);
        xfer("wh12",  1'b1, 32'h12, 3'd1, 32'h12340000, 1'b0, 32'h0);
        xfer("r10d",  1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'h1234AAEF);

        op_wr[0] = 1'b1; op_addr[0] = 32'h20; op_data[0] = 32'hA0A0_0020;
        op_wr[1] = 1'b1; op_addr[1] = 32'h24; op_data[1] = 32'hB1B1_0024;
        op_wr[2] = 1'b1; op_addr[2] = 32'h28; op_data[2] = 32'hC2C2_0028;
        op_wr[3] = 1'b1; op_addr[3] = 32'h2C; op_data[3] = 32'hD3D3_002C;
        op_wr[4] = 1'b0; op_addr[4] = 32'h2C; op_data[4] = 32'hD3D3_002C;
        op_wr[5] = 1'b0; op_addr[5] = 32'h20; op_data[5] = 32'hA0A0_0020;
        op_wr[6] = 1'b0; op_addr[6] = 32'h24; op_data[6] = 32'hB1B1_0024;
        op_wr[7] = 1'b0; op_addr[7] = 32'h28; op_data[7] = 32'hC2C2_0028;
        pipe(8);

        xfer("w30",   1'b1, 32'h30, 3'd2, 32'h12345678, 1'b0, 32'h0);
        hsel = 1'b1; htrans = 2'd2; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = 32'hFFFF0000;
        chk("rst_pre_hready", {31'd0, hready}, (EXP_W > 0) ? 32'd0 : 32'd1);
        #2;
        hreset = 1'b1;
        #1;
        chk("rst_mid_hready", {31'd0, hready}, 32'd1);
        chk("rst_mid_hresp", 32'(hresp), 32'd0);
        chk("rst_mid_hrdata", hrdata, 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(posedge hclk); #1;
        xfer("r30",   1'b0, 32'h30, 3'd2, 32'h0, 1'b0, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
